// File: rtl/rr_arbiter_sel2x4_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_sel2x4_if
// Brief    : Request vector and decoder-select bundle for rr_arbiter_sel2x4.
// Revision : 1.0
// ============================================================================
interface rr_arbiter_sel2x4_if;
    logic [3:0] req;
    logic       A;
    logic       B;
    logic       E;
    logic       busy;

    modport master (output req, input A, B, E, busy);
    modport slave  (input req, output A, B, E, busy);
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_sel2x4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_sel2x4
// Brief    : 4-way round-robin arbiter with grant hold/timeout, driving the
//            A/B/E inputs of a 2-to-4 active-low decoder from registers.
// Revision : 1.0
// ============================================================================
module rr_arbiter_sel2x4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rr_arbiter_sel2x4_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              r_a, w_a_nxt;
    logic              r_b, w_b_nxt;
    logic              r_e, w_e_nxt;

    logic [1:0]        w_idx;
    logic [3:0]        w_mask;
    logic              w_own;
    logic              w_others;
    logic              w_release;
    logic [1:0]        w_win_idle;
    logic [1:0]        w_win_swap;

    // First set bit of r scanning circularly from start+1; start itself is last.
    function automatic logic [1:0] f_next_after(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        f_next_after = start;
        found        = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                f_next_after = idx;
                found        = 1'b1;
            end
        end
    endfunction

    assign w_idx      = {r_a, r_b};
    assign w_mask     = 4'b0001 << w_idx;
    assign w_own      = bus.req[w_idx];
    assign w_others   = |(bus.req & ~w_mask);
    assign w_release  = !w_own || ((r_hold == C_HOLD_LAST) && w_others);
    assign w_win_idle = f_next_after(bus.req, r_ptr);
    assign w_win_swap = f_next_after(bus.req & ~w_mask, w_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd3;
            r_hold  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_e     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_e     <= w_e_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_e_nxt     = r_e;
        case (r_state)
            IDLE: begin
                w_e_nxt = 1'b1;
                if (|bus.req) begin
                    w_state_nxt        = GRANT;
                    {w_a_nxt, w_b_nxt} = w_win_idle;
                    w_e_nxt            = 1'b0;
                    w_hold_nxt         = '0;
                    w_ptr_nxt          = w_win_idle;
                end
            end
            GRANT: begin
                if (w_release) begin
                    if (w_others) begin
                        // Hand-off on the same edge keeps E low: no bubble.
                        {w_a_nxt, w_b_nxt} = w_win_swap;
                        w_hold_nxt         = '0;
                        w_ptr_nxt          = w_win_swap;
                    end else begin
                        w_state_nxt = IDLE;
                        w_e_nxt     = 1'b1;
                    end
                end else if (r_hold != C_HOLD_LAST) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_e_nxt     = 1'b1;
            end
        endcase
    end

    assign bus.A    = r_a;
    assign bus.B    = r_b;
    assign bus.E    = r_e;
    assign bus.busy = ~r_e;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_sel2x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_sel2x4
// Brief    : Directed + random bench for rr_arbiter_sel2x4 against a
//            cycle-level behavioural model of the arbitration rules.
// Revision : 1.0
// ============================================================================
module tb_rr_arbiter_sel2x4;

    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    // Reference model: granted requester (-1 = none), last winner, displayed
    // select index, and how many cycles the current holder has been granted.
    int   m_g;
    int   m_last;
    int   m_ab;
    int   m_ten;

    rr_arbiter_sel2x4_if bus ();

    rr_arbiter_sel2x4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_g    = -1;
        m_last = 3;
        m_ab   = 0;
        m_ten  = 0;
    endtask

    // First requester after 'after' in circular order, never 'skip'; -1 if none.
    function automatic int pick(input logic [3:0] r, input int after, input int skip);
        int j;
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
            j = (after + k) % 4;
            if (pick < 0 && j != skip && r[j]) pick = j;
        end
    endfunction

    task automatic model_edge(input logic [3:0] r);
        int w;
        if (m_g < 0) begin
            w = pick(r, m_last, -1);
            if (w >= 0) begin
                m_g = w; m_last = w; m_ab = w; m_ten = 1;
            end
        end else begin
            w = pick(r, m_g, m_g);
            if (!r[m_g] || (m_ten >= MAX_HOLD && w >= 0)) begin
                if (w >= 0) begin
                    m_g = w; m_last = w; m_ab = w; m_ten = 1;
                end else begin
                    m_g = -1;
                end
            end else begin
                m_ten++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_sel"}, {29'd0, bus.E, bus.A, bus.B},
              {29'd0, (m_g < 0) ? 1'b1 : 1'b0, 2'(m_ab)});
        check({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, (m_g >= 0) ? 1'b1 : 1'b0});
    endtask

    // Entered at a falling edge; drives req, advances one rising edge, checks.
    task automatic step(input logic [3:0] r, input string tag);
        bus.req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_model(tag);
        @(negedge clk);
    endtask

    logic [3:0] r_rand;

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_E", {31'd0, bus.E}, 32'd1);
        check("rst_AB", {30'd0, bus.A, bus.B}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);

        rst_n = 1'b1;
        step(4'b1111, "first");
        check("first_grant0", {29'd0, bus.E, bus.A, bus.B}, 32'd0);
        for (int i = 0; i < 33; i++) step(4'b1111, "rotate");

        step(4'b0000, "drain");
        step(4'b0000, "idle");
        step(4'b0100, "single");
        check("single_AB", {30'd0, bus.A, bus.B}, 32'd2);
        step(4'b0000, "single_drop");
        check("drop_E", {31'd0, bus.E}, 32'd1);
        check("drop_AB_held", {30'd0, bus.A, bus.B}, 32'd2);

        step(4'b0010, "hand_g1");
        step(4'b0110, "hand_hold");
        step(4'b0100, "hand_swap");
        check("hand_nobubble", {29'd0, bus.E, bus.A, bus.B}, 32'd2);

        step(4'b0000, "to_idle");
        for (int i = 0; i < 20; i++) step(4'b0001, "solo");
        check("solo_AB", {29'd0, bus.E, bus.A, bus.B}, 32'd0);
        step(4'b0011, "sat_release");
        check("sat_release_g1", {29'd0, bus.E, bus.A, bus.B}, 32'd1);

        step(4'b1111, "pre_async");
        step(4'b1111, "pre_async2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_E", {31'd0, bus.E}, 32'd1);
        check("async_AB", {30'd0, bus.A, bus.B}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1010, "post_async");
        check("post_async_g1", {29'd0, bus.E, bus.A, bus.B}, 32'd1);

        r_rand = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom);
            step(r_rand, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
